// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin (mod 2^WIDTH), Bout = unsigned borrow, one bit per clock LSB first.
// Latency WIDTH+1 edges from acceptance to done; start is ignored outside IDLE (no queueing).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // One full-subtractor cell applied to the current LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= Bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Publish only on the last bit so D/Bout never show a partial result.
                    if (r_cnt == LAST) begin
                        D       <= w_res_next;
                        Bout    <= w_br_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timing/arithmetic reference model checked every cycle plus directed literal cases.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: m_k counts edges since the accepting edge; the result is plain wide arithmetic.
    logic       m_act = 1'b0;
    int         m_k = 0;
    logic [W:0] m_res = '0;
    logic [W-1:0] m_D = '0;
    logic       m_Bout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act  <= 1'b0;
            m_k    <= 0;
            m_D    <= '0;
            m_Bout <= 1'b0;
        end else begin
            if (m_act && m_k == W - 1) begin
                m_D    <= m_res[W-1:0];
                m_Bout <= m_res[W];
            end
            if ((!m_act || m_k >= W + 1) && start) begin
                m_act <= 1'b1;
                m_k   <= 0;
                m_res <= {1'b0, A} - {1'b0, B} - {{W{1'b0}}, Bin};
            end else if (m_act) begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_busy, exp_done;
        exp_busy = m_act && (m_k < W);
        exp_done = m_act && (m_k == W);
        if (done) done_cnt++;
        if (!rst)
            chk("cycle{busy,done,Bout,D}", {21'd0, busy, done, Bout, D},
                {21'd0, exp_busy, exp_done, m_Bout, m_D});
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] exp_d, input logic exp_bout, input bit noise);
        int nb;
        int done_at;
        nb = 0;
        done_at = -1;
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            if (noise && i < W - 1) begin
                start = 1'($urandom_range(0, 1));
                A = W'($urandom);
                B = W'($urandom);
                Bin = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            if (busy) nb++;
            if (done && done_at < 0) done_at = i;
        end
        chk("op_busy_cycles", nb, W);
        chk("op_done_edge", done_at, W);
        chk("op_D", {24'd0, D}, {24'd0, exp_d});
        chk("op_Bout", {31'd0, Bout}, {31'd0, exp_bout});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int t[$];
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   rr;

        #3;
        chk("reset_outputs", {20'd0, busy, done, Bout, D, 1'b0},
            {20'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold_busy", {31'd0, busy}, 32'd0);

        do_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0);

        // Inputs and start changing mid-operation must not disturb it.
        @(negedge clk);
        A = 8'h10; B = 8'h01; Bin = 1'b0; start = 1'b1;
        dc0 = done_cnt;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); A = 8'hAA; B = 8'h0C; Bin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        chk("midop_done_count", done_cnt - dc0, 1);
        chk("midop_D", {24'd0, D}, 32'h0F);
        chk("midop_Bout", {31'd0, Bout}, 32'd0);
        chk("midop_no_restart", {31'd0, busy}, 32'd0);

        // Abort with reset after shift edge 4.
        @(negedge clk);
        A = 8'h55; B = 8'h22; Bin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs_zero", {21'd0, busy, done, Bout, D}, 32'd0);
        dc0 = done_cnt;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_D_held_zero", {24'd0, D}, 32'd0);
        do_op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        A = 8'h9C; B = 8'h3A; Bin = 1'b1; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) t.push_back(i);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_pulses", t.size(), 4);
        if (t.size() >= 3) begin
            chk("b2b_gap1", t[1] - t[0], 10);
            chk("b2b_gap2", t[2] - t[1], 10);
        end
        chk("b2b_D", {24'd0, D}, 32'h61);

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (n % 50 == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
            rr = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            do_op(ra, rb, rbin, rr[W-1:0], rr[W], (n % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
